// File: rtl/mips_mem_pkg.sv
// Shared types for the unified MIPS memory port: arbiter states, owner encoding
// and default bus widths.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/wait_timer.sv
// Wait counter for an outstanding memory access; expired is high on the edge
// at which the access has been outstanding for MAX_WAIT cycles.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  // Count starts at 0 on the grant edge, so the abort edge sees MAX_WAIT-1.
  assign expired = en && (cnt_q == 8'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch and
// data access; data wins, a watchdog aborts accesses memory never acknowledges.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] rdata_nxt;
  logic              tmr_clr, tmr_en, tmr_expired;
  owner_e            owner;

  assign owner  = (state_q == ST_DATA) ? OWN_DM : OWN_IF;
  assign tmr_en = (state_q != ST_IDLE) && !mem_ack;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    timeout_d   = timeout_q;
    tmr_clr     = 1'b0;
    rdata_nxt   = mem_rdata;
    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous read+write is issued as a write since mem_we follows dm_write.
        if (dm_read || dm_write) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          tmr_clr     = 1'b1;
        end else if (if_req) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = dm_wdata;
          tmr_clr     = 1'b1;
        end
      end
      ST_FETCH, ST_DATA: begin
        // An ack on the abort edge wins, so timeout is only raised without ack.
        if (mem_ack || tmr_expired) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          rdata_nxt = mem_ack ? mem_rdata : '0;
          if (!mem_ack) begin
            timeout_d = 1'b1;
          end
          if (owner == OWN_DM) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q || !mem_ack) begin
              dm_rdata_d = rdata_nxt;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = rdata_nxt;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign timeout   = timeout_q;
  assign stall     = ((dm_read || dm_write) && !dm_ready_q) || (if_req && !if_ready_q);

endmodule
